mem_access: RTL and testbench

- Memory stage directly downstream of execute.
- Consumes the memory_t request, the ALU result and the GPR write-enable produced by execute, and runs one Wishbone-classic data-bus transaction per load or store.
- Formats load data (byte/half extraction, sign/zero extension) and forwards the final writeback value to the writeback register.
- Stalls the pipeline while a transaction is outstanding and reports misalignment and bus faults.

---
 rtl/mem_access_pkg.sv | 67 ++++++
 rtl/mem_access_load_formatter.sv | 37 +++
 rtl/mem_access.sv | 164 ++++++++++++++++
 tb/tb_mem_access.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
//------------------------------------------------------------------------------
// mem_access_pkg
// Shared types for the memory stage: opcode, execute->memory request bundle,
// stage state encoding and small decode helpers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;

   typedef enum logic [3:0] {
      OP_NOP,
      OP_ALU,
      OP_LB,
      OP_LH,
      OP_LW,
      OP_LBU,
      OP_LHU,
      OP_SB,
      OP_SH,
      OP_SW
   } op_t;

   typedef struct packed {
      logic [31:0] address;
      logic [31:0] wdata;
      logic [3:0]  byte_en;
      logic        load;
      logic        store;
   } memory_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam int MEM_TIMEOUT_DEFAULT = 255;

   // Halfword accesses need bit 0 clear, word accesses need both low bits clear.
   function automatic logic addr_misaligned(input op_t op, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (op)
         OP_LH, OP_LHU, OP_SH: mis = off[0];
         OP_LW, OP_SW:         mis = (off != 2'b00);
         default:              mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Execute hands over the unshifted rs2 value; move sub-word data onto its lanes.
   function automatic logic [31:0] store_lanes(input op_t op, input logic [1:0] off,
                                               input logic [31:0] data);
      logic [31:0] lanes;
      lanes = data;
      case (op)
         OP_SB:   lanes = {24'b0, data[7:0]} << {off, 3'b000};
         OP_SH:   lanes = {16'b0, data[15:0]} << {off[1], 4'b0000};
         default: lanes = data;
      endcase
      return lanes;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_load_formatter.sv
//------------------------------------------------------------------------------
// load_formatter
// Combinational load data alignment: picks the addressed byte/half out of the
// bus word and sign- or zero-extends it to 32 bits.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_formatter
   import mem_access_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  offset,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection followed by extension according to the load flavour.
   always_comb begin
      byte_sel = raw[8*offset +: 8];
      half_sel = offset[1] ? raw[31:16] : raw[15:0];
      data     = raw;
      case (op_t'(op))
         OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  data = {24'b0, byte_sel};
         OP_LH:   data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  data = {16'b0, half_sel};
         default: data = raw;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
//------------------------------------------------------------------------------
// mem_access
// Memory stage: one Wishbone-classic transaction per load/store, load data
// formatting, pipeline stall while the bus is busy, misalignment and
// bus-error/timeout reporting.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  op_t         op,
   input  memory_t     memory,
   input  logic [31:0] gpr_wdata_in,
   input  logic        gpr_we_in,
   input  logic        except_in,
   output logic        stall_req,
   output logic [31:0] gpr_wdata,
   output logic        gpr_we,
   output logic        load_misaligned,
   output logic        store_misaligned,
   output logic        access_fault,
   output logic [31:0] fault_addr,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic [31:0] wb_dat_i
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             fault_pending;
   logic             is_load;
   logic [31:0]      lat_addr;
   logic [31:0]      result;
   logic [31:0]      load_fmt;

   logic access;
   logic misaligned;
   logic req;
   logic timeout_hit;

   assign access      = (memory.load | memory.store) & ~except_in;
   assign misaligned  = addr_misaligned(op, memory.address[1:0]);
   assign req         = access & ~misaligned;
   assign timeout_hit = (cnt == CNT_LAST);
   assign wb_adr_o    = {lat_addr[31:2], 2'b00};

   // Offset comes from the latched address; op is held stable by the stall.
   load_formatter u_fmt (
      .op     (op),
      .offset (lat_addr[1:0]),
      .raw    (wb_dat_i),
      .data   (load_fmt)
   );

   // Bus sequencer: launch from IDLE, wait for ack/err/timeout in BUSY,
   // release the pipeline for one cycle in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         fault_pending <= 1'b0;
         is_load       <= 1'b0;
         lat_addr      <= '0;
         result        <= '0;
         wb_cyc_o      <= 1'b0;
         wb_stb_o      <= 1'b0;
         wb_we_o       <= 1'b0;
         wb_dat_o      <= '0;
         wb_sel_o      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  lat_addr <= memory.address;
                  wb_dat_o <= store_lanes(op, memory.address[1:0], memory.wdata);
                  wb_sel_o <= memory.byte_en;
                  wb_we_o  <= memory.store;
                  is_load  <= memory.load;
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  cnt      <= '0;
                  result   <= '0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + CNT_W'(1);
               // Error beats a simultaneous ack; timeout only if no ack arrived.
               if (wb_err_i || (!wb_ack_i && timeout_hit)) begin
                  wb_cyc_o      <= 1'b0;
                  wb_stb_o      <= 1'b0;
                  fault_pending <= 1'b1;
                  state         <= DONE;
               end else if (wb_ack_i) begin
                  result   <= is_load ? load_fmt : 32'h0;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  state    <= DONE;
               end
            end
            DONE: begin
               fault_pending <= 1'b0;
               state         <= IDLE;
            end
            default: begin
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   // Stall, writeback and fault reporting towards the pipeline.
   always_comb begin
      stall_req        = 1'b0;
      gpr_wdata        = gpr_wdata_in;
      gpr_we           = 1'b0;
      load_misaligned  = 1'b0;
      store_misaligned = 1'b0;
      access_fault     = 1'b0;
      fault_addr       = lat_addr;
      case (state)
         IDLE: begin
            stall_req        = req;
            load_misaligned  = access & memory.load & misaligned;
            store_misaligned = access & memory.store & misaligned;
            fault_addr       = memory.address;
            gpr_we           = gpr_we_in & ~except_in & ~(access & misaligned) & ~req;
         end
         BUSY: begin
            stall_req = 1'b1;
         end
         DONE: begin
            access_fault = fault_pending;
            if (is_load) begin
               gpr_wdata = result;
               gpr_we    = gpr_we_in & ~fault_pending;
            end
         end
         default: begin
            stall_req = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
//------------------------------------------------------------------------------
// tb_mem_access
// Directed self-checking bench for the memory stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk;
   logic        rst_n;
   op_t         op;
   memory_t     memory;
   logic [31:0] gpr_wdata_in;
   logic        gpr_we_in;
   logic        except_in;
   logic        stall_req;
   logic [31:0] gpr_wdata;
   logic        gpr_we;
   logic        load_misaligned;
   logic        store_misaligned;
   logic        access_fault;
   logic [31:0] fault_addr;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic [31:0] wb_dat_i;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   // Observations captured by run_access
   int          stall_cycles;
   int          busy_cycles;
   logic        first_cyc;
   logic        cyc_after;
   logic [31:0] d_wdata;
   logic        d_we;
   logic        d_fault;
   logic [31:0] d_faddr;
   logic        d_lmis;
   logic        d_smis;
   logic        d_stall;
   logic [3:0]  c_sel;
   logic [31:0] c_dat;
   logic        c_we;
   logic [31:0] c_adr;
   logic        c_stb;

   mem_access #(.TIMEOUT_CYCLES(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .op               (op),
      .memory           (memory),
      .gpr_wdata_in     (gpr_wdata_in),
      .gpr_we_in        (gpr_we_in),
      .except_in        (except_in),
      .stall_req        (stall_req),
      .gpr_wdata        (gpr_wdata),
      .gpr_we           (gpr_we),
      .load_misaligned  (load_misaligned),
      .store_misaligned (store_misaligned),
      .access_fault     (access_fault),
      .fault_addr       (fault_addr),
      .wb_cyc_o         (wb_cyc_o),
      .wb_stb_o         (wb_stb_o),
      .wb_we_o          (wb_we_o),
      .wb_adr_o         (wb_adr_o),
      .wb_dat_o         (wb_dat_o),
      .wb_sel_o         (wb_sel_o),
      .wb_ack_i         (wb_ack_i),
      .wb_err_i         (wb_err_i),
      .wb_dat_i         (wb_dat_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      op             = OP_NOP;
      memory         = '0;
      gpr_wdata_in   = 32'h0;
      gpr_we_in      = 1'b0;
      except_in      = 1'b0;
      wb_ack_i       = 1'b0;
      wb_err_i       = 1'b0;
      wb_dat_i       = 32'h0;
   endtask

   // Drives one request and plays the slave. mode: 0 ack, 1 err, 2 silent,
   // 3 ack+err; the response comes in BUSY cycle number 'waits'.
   // Entered and left just after a rising edge.
   task automatic run_access(input op_t o, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, input logic ld, input logic st,
                             input logic ex, input int waits, input int mode,
                             input logic [31:0] rdata, input bit keep);
      int n;
      bit done;
      op           = o;
      memory       = '{address: a, wdata: wd, byte_en: be, load: ld, store: st};
      except_in    = ex;
      gpr_we_in    = 1'b1;
      gpr_wdata_in = 32'h1111_2222;
      stall_cycles = 0;
      busy_cycles  = 0;
      first_cyc    = 1'b0;
      n            = 0;
      done         = 1'b0;
      while (!done && n < 60) begin
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         if (wb_cyc_o && busy_cycles == waits) begin
            if (mode == 0 || mode == 3) begin
               wb_ack_i = 1'b1;
               wb_dat_i = rdata;
            end
            if (mode == 1 || mode == 3) wb_err_i = 1'b1;
         end
         @(negedge clk);
         if (n == 0) first_cyc = wb_cyc_o;
         if (stall_req) stall_cycles++;
         if (wb_cyc_o) begin
            busy_cycles++;
            c_sel = wb_sel_o;
            c_dat = wb_dat_o;
            c_we  = wb_we_o;
            c_adr = wb_adr_o;
            c_stb = wb_stb_o;
         end else if (busy_cycles > 0 || (n == 0 && !stall_req)) begin
            d_wdata = gpr_wdata;
            d_we    = gpr_we;
            d_fault = access_fault;
            d_faddr = fault_addr;
            d_lmis  = load_misaligned;
            d_smis  = store_misaligned;
            d_stall = stall_req;
            done    = 1'b1;
         end
         if (!done) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      assert_cnt++;
      if (!done) begin
         fail_cnt++;
         $display("FAIL access_bound: completed %0d required 1", done);
      end
      @(posedge clk);
      #1;
      cyc_after = wb_cyc_o;
      if (!keep) idle_inputs();
   endtask

   task automatic test_reset();
      #1;
      assert_cnt++; if (wb_cyc_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_cyc: got %b expected 0", wb_cyc_o); end
      assert_cnt++; if (wb_stb_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_stb: got %b expected 0", wb_stb_o); end
      assert_cnt++; if (wb_we_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_we: got %b expected 0", wb_we_o); end
      assert_cnt++; if (wb_sel_o !== 4'h0) begin fail_cnt++; $display("FAIL rst_sel: got %h expected 0", wb_sel_o); end
      assert_cnt++; if (wb_adr_o !== 32'h0) begin fail_cnt++; $display("FAIL rst_adr: got %h expected 0", wb_adr_o); end
      assert_cnt++; if (stall_req !== 1'b0) begin fail_cnt++; $display("FAIL rst_stall: got %b expected 0", stall_req); end
      assert_cnt++; if (access_fault !== 1'b0) begin fail_cnt++; $display("FAIL rst_fault: got %b expected 0", access_fault); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_passthrough();
      run_access(OP_ALU, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 2, 32'h0, 1'b0);
      assert_cnt++; if (d_wdata !== 32'h1111_2222) begin fail_cnt++; $display("FAIL pass_wdata: got %h expected 11112222", d_wdata); end
      assert_cnt++; if (d_we !== 1'b1) begin fail_cnt++; $display("FAIL pass_we: got %b expected 1", d_we); end
      assert_cnt++; if (d_stall !== 1'b0) begin fail_cnt++; $display("FAIL pass_stall: got %b expected 0", d_stall); end
   endtask

   task automatic test_lw_wait();
      run_access(OP_LW, 32'h8000_0004, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 2, 0, 32'hDEAD_BEEF, 1'b0);
      assert_cnt++; if (stall_cycles != 4) begin fail_cnt++; $display("FAIL lw_stall_cycles: got %0d expected 4", stall_cycles); end
      assert_cnt++; if (busy_cycles != 3) begin fail_cnt++; $display("FAIL lw_busy_cycles: got %0d expected 3", busy_cycles); end
      assert_cnt++; if (c_stb !== 1'b1) begin fail_cnt++; $display("FAIL lw_stb: got %b expected 1", c_stb); end
      assert_cnt++; if (c_adr !== 32'h8000_0004) begin fail_cnt++; $display("FAIL lw_adr: got %h expected 80000004", c_adr); end
      assert_cnt++; if (c_we !== 1'b0) begin fail_cnt++; $display("FAIL lw_we: got %b expected 0", c_we); end
      assert_cnt++; if (c_sel !== 4'b1111) begin fail_cnt++; $display("FAIL lw_sel: got %b expected 1111", c_sel); end
      assert_cnt++; if (d_wdata !== 32'hDEAD_BEEF) begin fail_cnt++; $display("FAIL lw_data: got %h expected deadbeef", d_wdata); end
      assert_cnt++; if (d_we !== 1'b1) begin fail_cnt++; $display("FAIL lw_gpr_we: got %b expected 1", d_we); end
      assert_cnt++; if (d_stall !== 1'b0 || d_fault !== 1'b0) begin fail_cnt++; $display("FAIL lw_done_flags: got stall=%b fault=%b expected 0 0", d_stall, d_fault); end
   endtask

   task automatic test_subword_loads();
      run_access(OP_LB, 32'h8000_0003, 32'h0, 4'b1000, 1'b1, 1'b0, 1'b0, 0, 0, 32'h80FF_1234, 1'b0);
      assert_cnt++; if (d_wdata !== 32'hFFFF_FF80) begin fail_cnt++; $display("FAIL lb_data: got %h expected ffffff80", d_wdata); end
      assert_cnt++; if (stall_cycles != 2 || busy_cycles != 1) begin fail_cnt++; $display("FAIL lb_latency: got stall=%0d busy=%0d expected 2 1", stall_cycles, busy_cycles); end
      run_access(OP_LBU, 32'h8000_0003, 32'h0, 4'b1000, 1'b1, 1'b0, 1'b0, 0, 0, 32'h80FF_1234, 1'b0);
      assert_cnt++; if (d_wdata !== 32'h0000_0080) begin fail_cnt++; $display("FAIL lbu_data: got %h expected 00000080", d_wdata); end
      run_access(OP_LH, 32'h8000_0002, 32'h0, 4'b1100, 1'b1, 1'b0, 1'b0, 1, 0, 32'h80FF_1234, 1'b0);
      assert_cnt++; if (d_wdata !== 32'hFFFF_80FF) begin fail_cnt++; $display("FAIL lh_data: got %h expected ffff80ff", d_wdata); end
      run_access(OP_LHU, 32'h8000_0000, 32'h0, 4'b0011, 1'b1, 1'b0, 1'b0, 0, 0, 32'h80FF_9234, 1'b0);
      assert_cnt++; if (d_wdata !== 32'h0000_9234) begin fail_cnt++; $display("FAIL lhu_data: got %h expected 00009234", d_wdata); end
      run_access(OP_LB, 32'h8000_0001, 32'h0, 4'b0010, 1'b1, 1'b0, 1'b0, 0, 0, 32'h80FF_1234, 1'b0);
      assert_cnt++; if (d_wdata !== 32'h0000_0012) begin fail_cnt++; $display("FAIL lb_pos_data: got %h expected 00000012", d_wdata); end
   endtask

   task automatic test_stores();
      run_access(OP_SH, 32'h8000_0002, 32'h0000_ABCD, 4'b1100, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 1'b0);
      assert_cnt++; if (c_sel !== 4'b1100) begin fail_cnt++; $display("FAIL sh_sel: got %b expected 1100", c_sel); end
      assert_cnt++; if (c_dat !== 32'hABCD_0000) begin fail_cnt++; $display("FAIL sh_dat: got %h expected abcd0000", c_dat); end
      assert_cnt++; if (c_we !== 1'b1) begin fail_cnt++; $display("FAIL sh_we: got %b expected 1", c_we); end
      assert_cnt++; if (c_adr !== 32'h8000_0000) begin fail_cnt++; $display("FAIL sh_adr: got %h expected 80000000", c_adr); end
      assert_cnt++; if (d_we !== 1'b0) begin fail_cnt++; $display("FAIL sh_gpr_we: got %b expected 0", d_we); end
      run_access(OP_SB, 32'h8000_0001, 32'h0000_005A, 4'b0010, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 1'b0);
      assert_cnt++; if (c_dat !== 32'h0000_5A00) begin fail_cnt++; $display("FAIL sb_dat: got %h expected 00005a00", c_dat); end
   endtask

   task automatic test_misaligned();
      run_access(OP_LW, 32'h8000_0001, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0);
      assert_cnt++; if (first_cyc !== 1'b0 || cyc_after !== 1'b0 || busy_cycles != 0) begin fail_cnt++; $display("FAIL lw_mis_nobus: got cyc=%b/%b busy=%0d expected 0 0 0", first_cyc, cyc_after, busy_cycles); end
      assert_cnt++; if (d_lmis !== 1'b1) begin fail_cnt++; $display("FAIL lw_mis_flag: got %b expected 1", d_lmis); end
      assert_cnt++; if (d_faddr !== 32'h8000_0001) begin fail_cnt++; $display("FAIL lw_mis_addr: got %h expected 80000001", d_faddr); end
      assert_cnt++; if (d_we !== 1'b0 || d_stall !== 1'b0) begin fail_cnt++; $display("FAIL lw_mis_we_stall: got we=%b stall=%b expected 0 0", d_we, d_stall); end
      run_access(OP_SH, 32'h8000_0003, 32'h1234, 4'b1000, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 1'b0);
      assert_cnt++; if (d_smis !== 1'b1 || d_lmis !== 1'b0) begin fail_cnt++; $display("FAIL sh_mis_flag: got s=%b l=%b expected 1 0", d_smis, d_lmis); end
      run_access(OP_LB, 32'h8000_0003, 32'h0, 4'b1000, 1'b1, 1'b1 ^ 1'b1, 1'b1, 0, 0, 32'h0, 1'b0);
      assert_cnt++; if (busy_cycles != 0 || d_we !== 1'b0 || d_lmis !== 1'b0) begin fail_cnt++; $display("FAIL except_suppress: got busy=%0d we=%b mis=%b expected 0 0 0", busy_cycles, d_we, d_lmis); end
   endtask

   task automatic test_faults();
      run_access(OP_LW, 32'h8000_0010, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 0, 2, 32'h0, 1'b0);
      assert_cnt++; if (busy_cycles != 4) begin fail_cnt++; $display("FAIL timeout_busy: got %0d expected 4", busy_cycles); end
      assert_cnt++; if (d_fault !== 1'b1 || d_we !== 1'b0) begin fail_cnt++; $display("FAIL timeout_fault: got fault=%b we=%b expected 1 0", d_fault, d_we); end
      assert_cnt++; if (d_faddr !== 32'h8000_0010) begin fail_cnt++; $display("FAIL timeout_addr: got %h expected 80000010", d_faddr); end
      assert_cnt++; if (cyc_after !== 1'b0) begin fail_cnt++; $display("FAIL fault_one_cycle: got cyc=%b expected 0", cyc_after); end
      run_access(OP_LW, 32'h8000_0020, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 1, 3, 32'h5555_5555, 1'b0);
      assert_cnt++; if (d_fault !== 1'b1 || d_we !== 1'b0 || busy_cycles != 2) begin fail_cnt++; $display("FAIL ack_err_fault: got fault=%b we=%b busy=%0d expected 1 0 2", d_fault, d_we, busy_cycles); end
      run_access(OP_SW, 32'h8000_0024, 32'h1, 4'b1111, 1'b0, 1'b1, 1'b0, 0, 1, 32'h0, 1'b0);
      assert_cnt++; if (d_fault !== 1'b1 || busy_cycles != 1) begin fail_cnt++; $display("FAIL err_fault: got fault=%b busy=%0d expected 1 1", d_fault, busy_cycles); end
      run_access(OP_LW, 32'h8000_0028, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 3, 0, 32'h0BAD_F00D, 1'b0);
      assert_cnt++; if (d_fault !== 1'b0 || d_wdata !== 32'h0BAD_F00D || busy_cycles != 4) begin fail_cnt++; $display("FAIL last_cycle_ack: got fault=%b data=%h busy=%0d expected 0 0badf00d 4", d_fault, d_wdata, busy_cycles); end
   endtask

   task automatic test_back_to_back();
      run_access(OP_LW, 32'h8000_0100, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0000_0001, 1'b1);
      run_access(OP_LW, 32'h8000_0104, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0000_0002, 1'b0);
      assert_cnt++; if (first_cyc !== 1'b0) begin fail_cnt++; $display("FAIL b2b_gap: got cyc=%b expected 0", first_cyc); end
      assert_cnt++; if (stall_cycles != 2 || d_wdata !== 32'h0000_0002) begin fail_cnt++; $display("FAIL b2b_second: got stall=%0d data=%h expected 2 00000002", stall_cycles, d_wdata); end
   endtask

   task automatic test_mid_reset();
      op        = OP_LW;
      memory    = '{address: 32'h8000_0200, wdata: 32'h0, byte_en: 4'b1111, load: 1'b1, store: 1'b0};
      gpr_we_in = 1'b1;
      @(posedge clk);
      #1;
      assert_cnt++; if (wb_cyc_o !== 1'b1) begin fail_cnt++; $display("FAIL mrst_busy: got cyc=%b expected 1", wb_cyc_o); end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      assert_cnt++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin fail_cnt++; $display("FAIL mrst_drop: got cyc=%b stb=%b expected 0 0", wb_cyc_o, wb_stb_o); end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      assert_cnt++; if (stall_req !== 1'b0 || wb_cyc_o !== 1'b0) begin fail_cnt++; $display("FAIL mrst_idle: got stall=%b cyc=%b expected 0 0", stall_req, wb_cyc_o); end
      @(posedge clk);
      #1;
      run_access(OP_LW, 32'h8000_0204, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 0, 0, 32'h1234_5678, 1'b0);
      assert_cnt++; if (stall_cycles != 2 || d_wdata !== 32'h1234_5678) begin fail_cnt++; $display("FAIL mrst_after: got stall=%0d data=%h expected 2 12345678", stall_cycles, d_wdata); end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      test_reset();
      test_passthrough();
      test_lw_wait();
      test_subword_loads();
      test_stores();
      test_misaligned();
      test_faults();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

`default_nettype wire
